// File: rtl/port_bind_table_if.sv
`default_nettype none
// ============================================================================
// Module   : port_bind_table_if
// Purpose  : Request/response and status bundle between the config agent
//            and the port bind table.
// Revision : 1.0
// ============================================================================
interface port_bind_table_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int PORT_W      = 16,
    parameter int OWNER_W     = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [PORT_W-1:0]  req_port;
    logic [OWNER_W-1:0] req_owner;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2:0]         rsp_status;
    logic [IDX_W-1:0]   rsp_index;
    logic [OWNER_W-1:0] rsp_owner;
    logic [CNT_W-1:0]   bound_count;
    logic               table_full;

    modport master (
        output req_valid, req_op, req_port, req_owner, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_index, rsp_owner,
               bound_count, table_full
    );

    modport slave (
        input  req_valid, req_op, req_port, req_owner, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_index, rsp_owner,
               bound_count, table_full
    );
endinterface
`default_nettype wire

// File: rtl/port_bind_table.sv
`default_nettype none
// ============================================================================
// Module   : port_bind_table
// Purpose  : N-entry port/owner bind table with serial scan, conflict
//            detection and occupancy reporting.
// Revision : 1.0
// ============================================================================
module port_bind_table #(
    parameter int NUM_ENTRIES = 8,
    parameter int PORT_W      = 16,
    parameter int OWNER_W     = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    port_bind_table_if.slave   bus
);
    localparam logic [1:0] c_OP_BIND   = 2'd0;
    localparam logic [1:0] c_OP_UNBIND = 2'd1;
    localparam logic [1:0] c_OP_LOOKUP = 2'd2;
    localparam logic [1:0] c_OP_RSVD   = 2'd3;

    localparam logic [2:0] c_ST_OK        = 3'd0;
    localparam logic [2:0] c_ST_TAKEN     = 3'd1;
    localparam logic [2:0] c_ST_FULL      = 3'd2;
    localparam logic [2:0] c_ST_NOT_FOUND = 3'd3;
    localparam logic [2:0] c_ST_DENIED    = 3'd4;
    localparam logic [2:0] c_ST_BAD_PORT  = 3'd5;
    localparam logic [2:0] c_ST_BAD_OP    = 3'd6;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_ent_valid [NUM_ENTRIES];
    logic [PORT_W-1:0]  r_ent_port  [NUM_ENTRIES];
    logic [OWNER_W-1:0] r_ent_owner [NUM_ENTRIES];

    logic [1:0]         r_op;
    logic [PORT_W-1:0]  r_port;
    logic [OWNER_W-1:0] r_owner;
    logic [IDX_W-1:0]   r_scan_idx;
    logic               r_hit;
    logic [IDX_W-1:0]   r_hit_idx;
    logic [OWNER_W-1:0] r_hit_owner;
    logic               r_free_found;
    logic [IDX_W-1:0]   r_free_idx;

    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [2:0]         r_rsp_status;
    logic [IDX_W-1:0]   r_rsp_index;
    logic [OWNER_W-1:0] r_rsp_owner;
    logic [CNT_W-1:0]   r_bound_count;

    logic               w_scan_valid;
    logic [PORT_W-1:0]  w_scan_port;
    logic [OWNER_W-1:0] w_scan_owner;

    assign w_scan_valid = r_ent_valid[r_scan_idx];
    assign w_scan_port  = r_ent_port[r_scan_idx];
    assign w_scan_owner = r_ent_owner[r_scan_idx];

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_status  = r_rsp_status;
    assign bus.rsp_index   = r_rsp_index;
    assign bus.rsp_owner   = r_rsp_owner;
    assign bus.bound_count = r_bound_count;
    assign bus.table_full  = (r_bound_count == CNT_W'(NUM_ENTRIES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_ent_valid[i] <= 1'b0;
                r_ent_port[i]  <= '0;
                r_ent_owner[i] <= '0;
            end
            r_op          <= '0;
            r_port        <= '0;
            r_owner       <= '0;
            r_scan_idx    <= '0;
            r_hit         <= 1'b0;
            r_hit_idx     <= '0;
            r_hit_owner   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= '0;
            r_rsp_index   <= '0;
            r_rsp_owner   <= '0;
            r_bound_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op         <= bus.req_op;
                        r_port       <= bus.req_port;
                        r_owner      <= bus.req_owner;
                        r_req_ready  <= 1'b0;
                        r_scan_idx   <= '0;
                        r_hit        <= 1'b0;
                        r_free_found <= 1'b0;
                        r_rsp_index  <= '0;
                        r_rsp_owner  <= '0;
                        if (bus.req_op == c_OP_RSVD) begin
                            r_rsp_status <= c_ST_BAD_OP;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (bus.req_port == '0) begin
                            r_rsp_status <= c_ST_BAD_PORT;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    // First match and lowest hole are both kept; later hits never overwrite.
                    if (w_scan_valid && (w_scan_port == r_port) && !r_hit) begin
                        r_hit       <= 1'b1;
                        r_hit_idx   <= r_scan_idx;
                        r_hit_owner <= w_scan_owner;
                    end
                    if (!w_scan_valid && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
                    if (r_scan_idx == c_LAST_IDX) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                    r_rsp_index <= r_hit ? r_hit_idx : '0;
                    r_rsp_owner <= r_hit ? r_hit_owner : '0;
                    case (r_op)
                        c_OP_BIND: begin
                            if (r_hit) begin
                                r_rsp_status <= c_ST_TAKEN;
                            end else if (!r_free_found) begin
                                r_rsp_status <= c_ST_FULL;
                            end else begin
                                r_ent_valid[r_free_idx] <= 1'b1;
                                r_ent_port[r_free_idx]  <= r_port;
                                r_ent_owner[r_free_idx] <= r_owner;
                                r_rsp_status  <= c_ST_OK;
                                r_rsp_index   <= r_free_idx;
                                r_bound_count <= r_bound_count + c_ONE;
                            end
                        end
                        c_OP_UNBIND: begin
                            if (!r_hit) begin
                                r_rsp_status <= c_ST_NOT_FOUND;
                            end else if (r_hit_owner != r_owner) begin
                                r_rsp_status <= c_ST_DENIED;
                            end else begin
                                r_ent_valid[r_hit_idx] <= 1'b0;
                                r_rsp_status  <= c_ST_OK;
                                r_bound_count <= r_bound_count - c_ONE;
                            end
                        end
                        c_OP_LOOKUP: begin
                            r_rsp_status <= r_hit ? c_ST_OK : c_ST_NOT_FOUND;
                        end
                        default: begin
                            r_rsp_status <= c_ST_BAD_OP;
                        end
                    endcase
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_port_bind_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_bind_table
// Purpose  : Scoreboard bench for port_bind_table against a behavioural table.
// Revision : 1.0
// ============================================================================
module tb_port_bind_table;
    localparam int NUM_ENTRIES = 8;
    localparam int PORT_W      = 16;
    localparam int OWNER_W     = 4;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;

    localparam logic [1:0] c_BIND = 2'd0, c_UNBIND = 2'd1, c_LOOKUP = 2'd2, c_RSVD = 2'd3;
    localparam logic [2:0] c_OK = 3'd0, c_TAKEN = 3'd1, c_FULL = 3'd2, c_NOT_FOUND = 3'd3,
                           c_DENIED = 3'd4, c_BAD_PORT = 3'd5, c_BAD_OP = 3'd6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    port_bind_table_if #(
        .NUM_ENTRIES(NUM_ENTRIES), .PORT_W(PORT_W), .OWNER_W(OWNER_W),
        .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) bus ();

    port_bind_table #(
        .NUM_ENTRIES(NUM_ENTRIES), .PORT_W(PORT_W), .OWNER_W(OWNER_W),
        .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]         st;
        logic [IDX_W-1:0]   idx;
        logic [OWNER_W-1:0] own;
        int                 lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    bit                 m_valid [NUM_ENTRIES];
    logic [PORT_W-1:0]  m_port  [NUM_ENTRIES];
    logic [OWNER_W-1:0] m_owner [NUM_ENTRIES];
    int                 m_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_ENTRIES; i++) m_valid[i] = 1'b0;
        m_count = 0;
    endtask

    // Behavioural table: first matching port, lowest free slot.
    task automatic model_step(input logic [1:0] op, input logic [PORT_W-1:0] port,
                              input logic [OWNER_W-1:0] owner, output exp_t e);
        int hit, fr;
        hit = -1; fr = -1;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (hit < 0 && m_valid[i] && m_port[i] == port) hit = i;
            if (fr < 0 && !m_valid[i]) fr = i;
        end
        e.idx = '0; e.own = '0; e.lat = NUM_ENTRIES + 2;
        if (op == c_RSVD) begin
            e.st = c_BAD_OP; e.lat = 1;
        end else if (port == '0) begin
            e.st = c_BAD_PORT; e.lat = 1;
        end else begin
            if (hit >= 0) begin
                e.idx = IDX_W'(hit); e.own = m_owner[hit];
            end
            case (op)
                c_BIND: begin
                    if (hit >= 0) e.st = c_TAKEN;
                    else if (fr < 0) e.st = c_FULL;
                    else begin
                        e.st = c_OK; e.idx = IDX_W'(fr);
                        m_valid[fr] = 1'b1; m_port[fr] = port; m_owner[fr] = owner;
                        m_count++;
                    end
                end
                c_UNBIND: begin
                    if (hit < 0) e.st = c_NOT_FOUND;
                    else if (m_owner[hit] != owner) e.st = c_DENIED;
                    else begin
                        e.st = c_OK; m_valid[hit] = 1'b0; m_count--;
                    end
                end
                default: e.st = (hit >= 0) ? c_OK : c_NOT_FOUND;
            endcase
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [PORT_W-1:0] port,
                          input logic [OWNER_W-1:0] owner, input int hold);
        exp_t e;
        exp_t g;
        int   lat;
        model_step(op, port, owner, e);
        sb.push_back(e);
        @(posedge clk); #1;
        check_val("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_port = port; bus.req_owner = owner;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 4 * NUM_ENTRIES) begin
            @(posedge clk); #1;
            lat++;
        end
        g = sb.pop_front();
        check_val("rsp_valid_seen", bus.rsp_valid, 1);
        check_val("latency", lat, g.lat);
        check_val("rsp_status", bus.rsp_status, g.st);
        check_val("rsp_index", bus.rsp_index, g.idx);
        check_val("rsp_owner", bus.rsp_owner, g.own);
        check_val("req_ready_busy", bus.req_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_val("hold_rsp_valid", bus.rsp_valid, 1);
            check_val("hold_status", bus.rsp_status, g.st);
            check_val("hold_index", bus.rsp_index, g.idx);
            check_val("hold_owner", bus.rsp_owner, g.own);
            check_val("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check_val("rsp_valid_drop", bus.rsp_valid, 0);
        check_val("req_ready_back", bus.req_ready, 1);
        check_val("bound_count", bus.bound_count, m_count);
        check_val("table_full", bus.table_full, (m_count == NUM_ENTRIES) ? 1 : 0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_port = '0; bus.req_owner = '0;
        bus.rsp_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rsp_valid", bus.rsp_valid, 0);
        check_val("rst_req_ready", bus.req_ready, 1);
        check_val("rst_status", bus.rsp_status, 0);
        check_val("rst_index", bus.rsp_index, 0);
        check_val("rst_owner", bus.rsp_owner, 0);
        check_val("rst_count", bus.bound_count, 0);
        check_val("rst_full", bus.table_full, 0);
        rst_n = 1'b1;

        do_req(c_BIND, 16'd80, 4'd1, 0);
        do_req(c_BIND, 16'd22202, 4'd2, 0);
        do_req(c_BIND, 16'd22202, 4'd3, 0);
        do_req(c_BIND, 16'd80, 4'd1, 0);
        for (int k = 0; k < 6; k++) do_req(c_BIND, 16'(1000 + k), 4'd3, 0);
        check_val("full_after_fill", bus.table_full, 1);
        do_req(c_BIND, 16'd8080, 4'd4, 0);
        do_req(c_BIND, 16'hFFFF, 4'd15, 0);

        do_req(c_UNBIND, 16'd1001, 4'd3, 0);
        do_req(c_BIND, 16'd443, 4'd7, 0);
        do_req(c_LOOKUP, 16'd443, 4'd0, 0);
        do_req(c_UNBIND, 16'd80, 4'd5, 0);
        do_req(c_LOOKUP, 16'd80, 4'd0, 0);
        do_req(c_UNBIND, 16'd9999, 4'd1, 0);
        do_req(c_BIND, 16'd0, 4'd1, 0);
        do_req(c_RSVD, 16'd80, 4'd1, 0);
        do_req(c_UNBIND, 16'd1005, 4'd3, 0);
        do_req(c_BIND, 16'hFFFF, 4'd15, 0);
        do_req(c_LOOKUP, 16'hFFFF, 4'd2, 5);

        // Reset in the middle of a scan must leave nothing behind.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_op = c_BIND; bus.req_port = 16'd5555; bus.req_owner = 4'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_rsp_valid", bus.rsp_valid, 0);
        check_val("midrst_req_ready", bus.req_ready, 1);
        check_val("midrst_count", bus.bound_count, 0);
        check_val("midrst_full", bus.table_full, 0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(c_LOOKUP, 16'd80, 4'd0, 0);
        do_req(c_LOOKUP, 16'd5555, 4'd0, 0);
        do_req(c_BIND, 16'd5555, 4'd9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
